// File: rtl/bit4_serial_receiver.sv
// Purpose: reassemble framed serial bits (MSB- or LSB-first per frame) into WIDTH-bit words.
// Latency: word is on y with out_valid one cycle after its last bit is sampled.
// Backpressure: one-entry output buffer; a word completing while the buffer is full and not draining is dropped and flags sticky overflow.
module bit4_serial_receiver #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ser_valid,
    input  logic             ser_bit,
    input  logic             ser_start,
    input  logic             lsb_first,
    input  logic             out_ready,
    input  logic             ovf_clr,
    output logic             out_valid,
    output logic [WIDTH-1:0] y,
    output logic             busy,
    output logic             frame_err,
    output logic             overflow
);

    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t           state;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] sr;
    logic             lsb_q;

    logic [WIDTH-1:0] start_word;
    logic [WIDTH-1:0] shift_word;
    logic             word_done;
    logic             buf_accept;

    // Next shift-register images and the completion / buffer-space decisions.
    always_comb begin
        start_word = '0;
        shift_word = '0;
        word_done  = 1'b0;
        buf_accept = 1'b0;
        // First bit lands at the end it will be shifted away from.
        if (lsb_first) begin
            start_word = {ser_bit, {(WIDTH-1){1'b0}}};
        end else begin
            start_word = {{(WIDTH-1){1'b0}}, ser_bit};
        end
        if (lsb_q) begin
            shift_word = {ser_bit, sr[WIDTH-1:1]};
        end else begin
            shift_word = {sr[WIDTH-2:0], ser_bit};
        end
        // A start strobe on the last bit position is a restart, never a completion.
        word_done  = (state == SHIFT) && ser_valid && !ser_start &&
                     (cnt == CW'(WIDTH - 1));
        // Buffer can take a new word if empty or being drained this cycle.
        buf_accept = !out_valid || out_ready;
    end

    // Frame FSM, shift register, output buffer and status flags.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            cnt       <= '0;
            sr        <= '0;
            lsb_q     <= 1'b0;
            y         <= '0;
            out_valid <= 1'b0;
            frame_err <= 1'b0;
            overflow  <= 1'b0;
        end else begin
            frame_err <= 1'b0;

            case (state)
                IDLE: begin
                    if (ser_valid && ser_start) begin
                        lsb_q <= lsb_first;
                        sr    <= start_word;
                        cnt   <= CW'(1);
                        state <= SHIFT;
                    end
                end
                SHIFT: begin
                    if (ser_valid) begin
                        if (ser_start) begin
                            // Abandon the partial word and begin again with this bit.
                            lsb_q     <= lsb_first;
                            sr        <= start_word;
                            cnt       <= CW'(1);
                            frame_err <= 1'b1;
                        end else if (cnt == CW'(WIDTH - 1)) begin
                            sr    <= '0;
                            cnt   <= '0;
                            state <= IDLE;
                        end else begin
                            sr  <= shift_word;
                            cnt <= cnt + CW'(1);
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                    cnt   <= '0;
                end
            endcase

            // y only moves when the buffer is empty or its word leaves this cycle.
            if (word_done && buf_accept) begin
                y         <= shift_word;
                out_valid <= 1'b1;
            end else if (out_valid && out_ready) begin
                out_valid <= 1'b0;
            end

            // Clear first so a coinciding drop still sets the flag.
            if (ovf_clr) begin
                overflow <= 1'b0;
            end
            if (word_done && !buf_accept) begin
                overflow <= 1'b1;
            end
        end
    end

    assign busy = (state == SHIFT);

endmodule

// File: tb/tb_bit4_serial_receiver.sv
// Purpose: directed checks of framing, bit order, restart, buffering and reset for bit4_serial_receiver.
// Latency: inputs change 1ns after a rising edge, outputs are checked 1ns after the next edge.
// Backpressure: out_ready is driven directly by each test step.
module tb_bit4_serial_receiver;

    logic       clk;
    logic       rst_n;
    logic       ser_valid;
    logic       ser_bit;
    logic       ser_start;
    logic       lsb_first;
    logic       out_ready;
    logic       ovf_clr;
    logic       out_valid;
    logic [3:0] y;
    logic       busy;
    logic       frame_err;
    logic       overflow;

    int n_pass;
    int n_total;

    bit4_serial_receiver #(.WIDTH(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .ser_valid (ser_valid),
        .ser_bit   (ser_bit),
        .ser_start (ser_start),
        .lsb_first (lsb_first),
        .out_ready (out_ready),
        .ovf_clr   (ovf_clr),
        .out_valid (out_valid),
        .y         (y),
        .busy      (busy),
        .frame_err (frame_err),
        .overflow  (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic send_bit(input logic b, input logic st, input logic lsb);
        ser_valid = 1'b1;
        ser_bit   = b;
        ser_start = st;
        lsb_first = lsb;
        tick();
        ser_valid = 1'b0;
        ser_start = 1'b0;
        ser_bit   = 1'b0;
    endtask

    // Sends a whole frame in the requested order with optional idle gaps.
    task automatic send_word(input logic [3:0] w, input logic lsb, input int gap);
        for (int i = 0; i < 4; i++) begin
            send_bit(lsb ? w[i] : w[3-i], (i == 0), lsb);
            if (i != 3) idle(gap);
        end
    endtask

    initial begin
        n_pass    = 0;
        n_total   = 0;
        rst_n     = 1'b0;
        ser_valid = 1'b0;
        ser_bit   = 1'b0;
        ser_start = 1'b0;
        lsb_first = 1'b0;
        out_ready = 1'b0;
        ovf_clr   = 1'b0;
        idle(2);

        chk("rst_y", y, 0);
        chk("rst_valid", out_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_ferr", frame_err, 0);
        chk("rst_ovf", overflow, 0);
        rst_n = 1'b1;
        idle(1);

        // Non-start bit in IDLE is ignored.
        send_bit(1'b1, 1'b0, 1'b0);
        chk("idle_ignore_busy", busy, 0);

        // MSB-first 1,0,1,0 -> A, valid exactly one cycle.
        out_ready = 1'b1;
        send_bit(1'b1, 1'b1, 1'b0);
        chk("a_busy", busy, 1);
        send_bit(1'b0, 1'b0, 1'b0);
        send_bit(1'b1, 1'b0, 1'b0);
        chk("a_valid_early", out_valid, 0);
        send_bit(1'b0, 1'b0, 1'b0);
        chk("a_valid", out_valid, 1);
        chk("a_y", y, 4'hA);
        chk("a_busy_done", busy, 0);
        idle(1);
        chk("a_valid_drop", out_valid, 0);

        // LSB-first 0,0,1,0 -> 4, without and with 3-cycle gaps.
        send_word(4'h4, 1'b1, 0);
        chk("lsb_valid", out_valid, 1);
        chk("lsb_y", y, 4'h4);
        idle(1);
        send_word(4'h4, 1'b1, 3);
        chk("lsb_gap_valid", out_valid, 1);
        chk("lsb_gap_y", y, 4'h4);
        idle(1);

        // Restart after two bits -> frame_err pulse, then C.
        send_bit(1'b1, 1'b1, 1'b0);
        send_bit(1'b0, 1'b0, 1'b0);
        send_bit(1'b1, 1'b1, 1'b0);
        chk("restart_ferr", frame_err, 1);
        chk("restart_busy", busy, 1);
        send_bit(1'b1, 1'b0, 1'b0);
        chk("restart_ferr_pulse", frame_err, 0);
        send_bit(1'b0, 1'b0, 1'b0);
        send_bit(1'b0, 1'b0, 1'b0);
        chk("restart_y", y, 4'hC);
        chk("restart_valid", out_valid, 1);
        idle(1);

        // Start strobe on the 4th bit restarts instead of completing.
        send_word(4'h5, 1'b0, 0);
        idle(1);
        send_bit(1'b1, 1'b1, 1'b0);
        send_bit(1'b1, 1'b0, 1'b0);
        send_bit(1'b1, 1'b0, 1'b0);
        send_bit(1'b0, 1'b1, 1'b0);
        chk("late_start_ferr", frame_err, 1);
        chk("late_start_valid", out_valid, 0);
        chk("late_start_busy", busy, 1);
        send_bit(1'b1, 1'b0, 1'b0);
        send_bit(1'b1, 1'b0, 1'b0);
        send_bit(1'b0, 1'b0, 1'b0);
        chk("late_start_y", y, 4'h6);
        idle(1);

        // Full buffer: 3 then 5 -> 3 kept, overflow; clear; drain.
        out_ready = 1'b0;
        send_word(4'h3, 1'b0, 0);
        chk("ovf_first_y", y, 4'h3);
        send_word(4'h5, 1'b0, 1);
        chk("ovf_y_hold", y, 4'h3);
        chk("ovf_valid_hold", out_valid, 1);
        chk("ovf_set", overflow, 1);
        ovf_clr = 1'b1;
        idle(1);
        ovf_clr = 1'b0;
        chk("ovf_clr", overflow, 0);
        // Clear coinciding with another drop: set wins.
        send_bit(1'b0, 1'b1, 1'b0);
        send_bit(1'b1, 1'b0, 1'b0);
        send_bit(1'b1, 1'b0, 1'b0);
        ovf_clr = 1'b1;
        send_bit(1'b1, 1'b0, 1'b0);
        ovf_clr = 1'b0;
        chk("ovf_set_wins", overflow, 1);
        chk("ovf_y_hold2", y, 4'h3);
        ovf_clr = 1'b1;
        idle(1);
        ovf_clr = 1'b0;
        chk("ovf_clr2", overflow, 0);
        out_ready = 1'b1;
        idle(1);
        chk("ovf_drain", out_valid, 0);

        // Pending word drained on the very cycle 9 completes.
        out_ready = 1'b0;
        send_word(4'h6, 1'b0, 0);
        chk("pend_y", y, 4'h6);
        send_bit(1'b1, 1'b1, 1'b0);
        send_bit(1'b0, 1'b0, 1'b0);
        send_bit(1'b0, 1'b0, 1'b0);
        out_ready = 1'b1;
        send_bit(1'b1, 1'b0, 1'b0);
        chk("b2b_valid", out_valid, 1);
        chk("b2b_y", y, 4'h9);
        chk("b2b_ovf", overflow, 0);
        idle(1);
        chk("b2b_drop", out_valid, 0);

        // Reset mid-frame with a buffered word, then F.
        out_ready = 1'b0;
        send_word(4'h5, 1'b0, 0);
        send_bit(1'b1, 1'b1, 1'b0);
        send_bit(1'b1, 1'b0, 1'b0);
        rst_n = 1'b0;
        idle(1);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_valid", out_valid, 0);
        chk("mid_rst_y", y, 0);
        rst_n = 1'b1;
        out_ready = 1'b1;
        send_word(4'hF, 1'b0, 0);
        chk("post_rst_y", y, 4'hF);
        chk("post_rst_valid", out_valid, 1);
        idle(2);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
